// File: rtl/cb_rd_arbiter_pkg.sv
// Shared types for the core-bus read arbiter: the bus structs, master select and a helper.
package cb_rd_arbiter_pkg;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_sel_t;

    typedef struct packed {
        logic [31:0] rd_addr;
        logic [2:0]  rd_size;
        logic        rd_addr_valid;
        logic        rd_ready;
        logic [31:0] wr_addr;
        logic [2:0]  wr_size;
        logic        wr_addr_valid;
        logic [31:0] wr_data;
        logic [3:0]  wr_strb;
        logic        wr_data_valid;
        logic        bready;
    } s_cb_mosi_t;

    typedef struct packed {
        logic        rd_addr_ready;
        logic        rd_valid;
        logic [31:0] rd_data;
        logic [1:0]  rd_resp;
        logic        wr_addr_ready;
        logic        wr_data_ready;
        logic        bvalid;
        logic [1:0]  bresp;
    } s_cb_miso_t;

    function automatic arb_sel_t other_master(input arb_sel_t sel);
        return (sel == ARB_DATA) ? ARB_INSTR : ARB_DATA;
    endfunction

endpackage

// File: rtl/cb_rd_arbiter_fifo.sv
// Small synchronous FIFO holding the source tag of each outstanding read.
module cb_rd_arbiter_fifo #(
    parameter int SLOTS = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(SLOTS):0]   count_o
);
    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_W = $clog2(SLOTS) + 1;

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(SLOTS - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Full/empty come from registered occupancy only, so a pop never frees a slot for a push in the same cycle.
    assign full_o  = (count == CNT_W'(SLOTS));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];
    assign count_o = count;

    // Storage needs no reset; occupancy decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cb_rd_arbiter.sv
// Shares one core-bus slave between the fetch and LSU masters: arbitrates read
// addresses, routes in-order read responses by source tag, and passes the LSU
// write channel straight through.
//
// lock | meaning
// 0    | grant free to move to whichever master the arbitration picks
// 1    | granted request is waiting on the slave; grant held until handshake
module cb_rd_arbiter
    import cb_rd_arbiter_pkg::*;
#(
    parameter int MAX_OT_TXN = 4,
    parameter int ARB_MODE   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  s_cb_mosi_t                    instr_cb_mosi_i,
    output s_cb_miso_t                    instr_cb_miso_o,
    input  s_cb_mosi_t                    data_cb_mosi_i,
    output s_cb_miso_t                    data_cb_miso_o,
    output s_cb_mosi_t                    cb_mosi_o,
    input  s_cb_miso_t                    cb_miso_i,
    output logic                          unexp_resp_o,
    output logic [$clog2(MAX_OT_TXN):0]   ot_cnt_o
);
    if (MAX_OT_TXN < 1) begin : g_param_check
        $error("cb_rd_arbiter: MAX_OT_TXN must be greater than 0");
    end

    arb_sel_t  grant_q;
    arb_sel_t  rr_q;
    arb_sel_t  gnt;
    arb_sel_t  head_sel;
    logic      lock_q;
    logic      instr_v;
    logic      data_v;
    logic      gnt_v;
    logic      addr_ok;
    logic      accept;
    logic      tag_full;
    logic      tag_empty;
    logic      head_ready;
    logic      pop;
    logic [0:0] tag_head;
    logic      unused_instr_wr;

    assign instr_v  = instr_cb_mosi_i.rd_addr_valid;
    assign data_v   = data_cb_mosi_i.rd_addr_valid;
    assign head_sel = arb_sel_t'(tag_head);

    // The fetch master has no write channel; its write fields are deliberately ignored.
    assign unused_instr_wr = ^instr_cb_mosi_i;

    // Pick this cycle's grant; a pending (locked) request always keeps the bus.
    always_comb begin
        gnt = grant_q;
        if (lock_q) begin
            gnt = grant_q;
        end else if (instr_v && data_v) begin
            gnt = (ARB_MODE != 0) ? rr_q : ARB_DATA;
        end else if (data_v) begin
            gnt = ARB_DATA;
        end else if (instr_v) begin
            gnt = ARB_INSTR;
        end
    end

    assign gnt_v   = (gnt == ARB_DATA) ? data_v : instr_v;
    assign addr_ok = cb_miso_i.rd_addr_ready && !tag_full;
    assign accept  = gnt_v && addr_ok;

    // Responses go to the head-tag master; with nothing outstanding the slave is drained.
    assign head_ready   = tag_empty ? 1'b1
                        : (head_sel == ARB_DATA) ? data_cb_mosi_i.rd_ready
                                                 : instr_cb_mosi_i.rd_ready;
    assign pop          = cb_miso_i.rd_valid && head_ready && !tag_empty;
    assign unexp_resp_o = cb_miso_i.rd_valid && tag_empty;

    // Slave-side request: LSU write fields pass through, read fields come from the grant.
    always_comb begin
        cb_mosi_o               = data_cb_mosi_i;
        cb_mosi_o.rd_addr       = (gnt == ARB_DATA) ? data_cb_mosi_i.rd_addr : instr_cb_mosi_i.rd_addr;
        cb_mosi_o.rd_size       = (gnt == ARB_DATA) ? data_cb_mosi_i.rd_size : instr_cb_mosi_i.rd_size;
        cb_mosi_o.rd_addr_valid = gnt_v && !tag_full;
        cb_mosi_o.rd_ready      = head_ready;
    end

    // Master-side responses: address ready to the grantee, read data to the head tag.
    always_comb begin
        instr_cb_miso_o               = '0;
        data_cb_miso_o                = '0;
        data_cb_miso_o.wr_addr_ready  = cb_miso_i.wr_addr_ready;
        data_cb_miso_o.wr_data_ready  = cb_miso_i.wr_data_ready;
        data_cb_miso_o.bvalid         = cb_miso_i.bvalid;
        data_cb_miso_o.bresp          = cb_miso_i.bresp;
        instr_cb_miso_o.rd_addr_ready = (gnt == ARB_INSTR) && addr_ok;
        data_cb_miso_o.rd_addr_ready  = (gnt == ARB_DATA) && addr_ok;
        if (!tag_empty) begin
            if (head_sel == ARB_DATA) begin
                data_cb_miso_o.rd_valid  = cb_miso_i.rd_valid;
                data_cb_miso_o.rd_data   = cb_miso_i.rd_data;
                data_cb_miso_o.rd_resp   = cb_miso_i.rd_resp;
            end else begin
                instr_cb_miso_o.rd_valid = cb_miso_i.rd_valid;
                instr_cb_miso_o.rd_data  = cb_miso_i.rd_data;
                instr_cb_miso_o.rd_resp  = cb_miso_i.rd_resp;
            end
        end
    end

    // Grant, lock and round-robin pointer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= ARB_DATA;
            lock_q  <= 1'b0;
            rr_q    <= ARB_INSTR;
        end else begin
            grant_q <= gnt;
            lock_q  <= gnt_v && !accept;
            if (accept) begin
                rr_q <= other_master(gnt);
            end
        end
    end

    cb_rd_arbiter_fifo #(
        .SLOTS (MAX_OT_TXN),
        .WIDTH (1)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (1'b0),
        .push_i  (accept),
        .data_i  (gnt),
        .pop_i   (pop),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (ot_cnt_o)
    );

endmodule

// File: tb/tb_cb_rd_arbiter.sv
// Bench for cb_rd_arbiter: a fixed-priority instance (2 outstanding) and a
// round-robin instance (4 outstanding), with scoreboard monitors on address
// accepts and delivered read responses plus directed point checks.
module tb_cb_rd_arbiter;
    import cb_rd_arbiter_pkg::*;

    typedef struct packed {
        logic        sel;
        logic [31:0] data;
    } resp_t;

    logic clk;
    logic rst;

    s_cb_mosi_t f_instr_mosi, f_data_mosi, f_cb_mosi;
    s_cb_miso_t f_instr_miso, f_data_miso, f_slv_miso;
    logic       f_unexp;
    logic [1:0] f_ot;

    s_cb_mosi_t r_instr_mosi, r_data_mosi, r_cb_mosi;
    s_cb_miso_t r_instr_miso, r_data_miso, r_slv_miso;
    logic       r_unexp;
    logic [2:0] r_ot;

    logic [31:0] f_exp_addr[$];
    logic [31:0] r_exp_addr[$];
    resp_t       f_exp_resp[$];

    int n_checks = 0;
    int n_errors = 0;

    cb_rd_arbiter #(.MAX_OT_TXN(2), .ARB_MODE(0)) dut_fix (
        .clk             (clk),
        .rst             (rst),
        .instr_cb_mosi_i (f_instr_mosi),
        .instr_cb_miso_o (f_instr_miso),
        .data_cb_mosi_i  (f_data_mosi),
        .data_cb_miso_o  (f_data_miso),
        .cb_mosi_o       (f_cb_mosi),
        .cb_miso_i       (f_slv_miso),
        .unexp_resp_o    (f_unexp),
        .ot_cnt_o        (f_ot)
    );

    cb_rd_arbiter #(.MAX_OT_TXN(4), .ARB_MODE(1)) dut_rr (
        .clk             (clk),
        .rst             (rst),
        .instr_cb_mosi_i (r_instr_mosi),
        .instr_cb_miso_o (r_instr_miso),
        .data_cb_mosi_i  (r_data_mosi),
        .data_cb_miso_o  (r_data_miso),
        .cb_mosi_o       (r_cb_mosi),
        .cb_miso_i       (r_slv_miso),
        .unexp_resp_o    (r_unexp),
        .ot_cnt_o        (r_ot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Address scoreboard: every accepted slave address must match the next expected one.
    always @(negedge clk) begin
        if (!rst) begin
            if (f_cb_mosi.rd_addr_valid && f_slv_miso.rd_addr_ready) begin
                if (f_exp_addr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL f_addr: accepted 0x%0h, expected no accept", f_cb_mosi.rd_addr);
                end else begin
                    chk("f_addr", 64'(f_cb_mosi.rd_addr), 64'(f_exp_addr.pop_front()));
                end
            end
            if (r_cb_mosi.rd_addr_valid && r_slv_miso.rd_addr_ready) begin
                if (r_exp_addr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL r_addr: accepted 0x%0h, expected no accept", r_cb_mosi.rd_addr);
                end else begin
                    chk("r_addr", 64'(r_cb_mosi.rd_addr), 64'(r_exp_addr.pop_front()));
                end
            end
        end
    end

    // Response scoreboard: each response taken by a master must match master id and data in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (f_data_miso.rd_valid && f_data_mosi.rd_ready) begin
                if (f_exp_resp.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL f_resp: data master got 0x%0h, expected no response", f_data_miso.rd_data);
                end else begin
                    chk("f_resp", 64'({1'b1, f_data_miso.rd_data}), 64'(f_exp_resp.pop_front()));
                end
            end
            if (f_instr_miso.rd_valid && f_instr_mosi.rd_ready) begin
                if (f_exp_resp.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL f_resp: instr master got 0x%0h, expected no response", f_instr_miso.rd_data);
                end else begin
                    chk("f_resp", 64'({1'b0, f_instr_miso.rd_data}), 64'(f_exp_resp.pop_front()));
                end
            end
        end
    end

    initial begin
        f_instr_mosi = '0; f_data_mosi = '0; f_slv_miso = '0;
        r_instr_mosi = '0; r_data_mosi = '0; r_slv_miso = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #2;
        chk("rst_f_ot",         64'(f_ot), 64'h0);
        chk("rst_f_unexp",      64'(f_unexp), 64'h0);
        chk("rst_f_addr_valid", 64'(f_cb_mosi.rd_addr_valid), 64'h0);
        chk("rst_f_instr_miso", 64'(f_instr_miso), 64'h0);
        chk("rst_f_data_miso",  64'(f_data_miso), 64'h0);
        chk("rst_r_ot",         64'(r_ot), 64'h0);

        // Write channel pass-through; fetch write requests are ignored.
        f_data_mosi.wr_addr       = 32'h0000_4000;
        f_data_mosi.wr_data       = 32'h1234_5678;
        f_data_mosi.wr_strb       = 4'hf;
        f_data_mosi.wr_addr_valid = 1'b1;
        f_data_mosi.wr_data_valid = 1'b1;
        f_instr_mosi.wr_addr      = 32'h0000_9999;
        f_instr_mosi.wr_addr_valid = 1'b1;
        f_slv_miso.wr_addr_ready  = 1'b1;
        f_slv_miso.wr_data_ready  = 1'b1;
        f_slv_miso.bvalid         = 1'b1;
        f_slv_miso.bresp          = 2'b10;
        #2;
        chk("wr_addr",        64'(f_cb_mosi.wr_addr), 64'h4000);
        chk("wr_data",        64'(f_cb_mosi.wr_data), 64'h1234_5678);
        chk("wr_addr_valid",  64'(f_cb_mosi.wr_addr_valid), 64'h1);
        chk("data_bresp",     64'(f_data_miso.bresp), 64'h2);
        chk("data_wr_ready",  64'(f_data_miso.wr_addr_ready), 64'h1);
        chk("instr_wr_ready", 64'(f_instr_miso.wr_addr_ready), 64'h0);
        chk("instr_bvalid",   64'(f_instr_miso.bvalid), 64'h0);
        tick();
        f_data_mosi = '0; f_instr_mosi = '0; f_slv_miso = '0;

        // Fixed priority: data wins, instr follows, then the tag FIFO is full.
        f_slv_miso.rd_addr_ready = 1'b1;
        f_data_mosi.rd_ready     = 1'b1;
        f_instr_mosi.rd_ready    = 1'b1;
        f_instr_mosi.rd_addr       = 32'h0000_0000;
        f_instr_mosi.rd_addr_valid = 1'b1;
        f_data_mosi.rd_addr        = 32'h0000_2000;
        f_data_mosi.rd_addr_valid  = 1'b1;
        f_exp_addr.push_back(32'h0000_2000);
        #2;
        chk("fix_data_ready",  64'(f_data_miso.rd_addr_ready), 64'h1);
        chk("fix_instr_ready", 64'(f_instr_miso.rd_addr_ready), 64'h0);
        tick();
        f_data_mosi.rd_addr_valid = 1'b0;
        f_exp_addr.push_back(32'h0000_0000);
        #2;
        chk("fix_ot1",          64'(f_ot), 64'h1);
        chk("fix_instr_ready2", 64'(f_instr_miso.rd_addr_ready), 64'h1);
        tick();
        f_instr_mosi.rd_addr_valid = 1'b0;
        f_data_mosi.rd_addr        = 32'h0000_3000;
        f_data_mosi.rd_addr_valid  = 1'b1;
        f_slv_miso.rd_valid        = 1'b1;
        f_slv_miso.rd_data         = 32'h0000_AAAA;
        f_exp_resp.push_back('{sel: 1'b1, data: 32'h0000_AAAA});
        #2;
        chk("full_ot",          64'(f_ot), 64'h2);
        chk("full_addr_valid",  64'(f_cb_mosi.rd_addr_valid), 64'h0);
        chk("full_data_ready",  64'(f_data_miso.rd_addr_ready), 64'h0);
        chk("full_instr_ready", 64'(f_instr_miso.rd_addr_ready), 64'h0);
        chk("resp1_instr_vld",  64'(f_instr_miso.rd_valid), 64'h0);
        tick();
        f_slv_miso.rd_data = 32'h0000_BBBB;
        f_exp_resp.push_back('{sel: 1'b0, data: 32'h0000_BBBB});
        f_exp_addr.push_back(32'h0000_3000);
        #2;
        chk("pop_ot",          64'(f_ot), 64'h1);
        chk("refill_ready",    64'(f_data_miso.rd_addr_ready), 64'h1);
        chk("resp2_data_vld",  64'(f_data_miso.rd_valid), 64'h0);
        tick();

        // Head master back-pressures a response for two cycles.
        f_data_mosi.rd_addr_valid = 1'b0;
        f_data_mosi.rd_ready      = 1'b0;
        f_slv_miso.rd_data        = 32'h0000_CCCC;
        #2;
        chk("stall_ot",        64'(f_ot), 64'h1);
        chk("stall_rd_ready",  64'(f_cb_mosi.rd_ready), 64'h0);
        chk("stall_data_vld",  64'(f_data_miso.rd_valid), 64'h1);
        chk("stall_data",      64'(f_data_miso.rd_data), 64'hCCCC);
        tick();
        #2;
        chk("stall2_ot",       64'(f_ot), 64'h1);
        chk("stall2_rd_ready", 64'(f_cb_mosi.rd_ready), 64'h0);
        tick();
        f_data_mosi.rd_ready = 1'b1;
        f_exp_resp.push_back('{sel: 1'b1, data: 32'h0000_CCCC});
        #2;
        chk("release_rd_ready", 64'(f_cb_mosi.rd_ready), 64'h1);
        tick();
        f_slv_miso.rd_valid = 1'b0;
        #2;
        chk("drained_ot", 64'(f_ot), 64'h0);

        // Lock: instr waits on a busy slave while data becomes valid.
        f_slv_miso.rd_addr_ready   = 1'b0;
        f_instr_mosi.rd_addr       = 32'h0000_0040;
        f_instr_mosi.rd_addr_valid = 1'b1;
        #2;
        chk("lock_addr0",       64'(f_cb_mosi.rd_addr), 64'h40);
        chk("lock_valid0",      64'(f_cb_mosi.rd_addr_valid), 64'h1);
        tick();
        f_data_mosi.rd_addr       = 32'h0000_2040;
        f_data_mosi.rd_addr_valid = 1'b1;
        #2;
        chk("lock_addr1",       64'(f_cb_mosi.rd_addr), 64'h40);
        chk("lock_data_ready1", 64'(f_data_miso.rd_addr_ready), 64'h0);
        tick();
        #2;
        chk("lock_addr2",       64'(f_cb_mosi.rd_addr), 64'h40);
        tick();
        f_slv_miso.rd_addr_ready = 1'b1;
        f_exp_addr.push_back(32'h0000_0040);
        #2;
        chk("lock_instr_ready", 64'(f_instr_miso.rd_addr_ready), 64'h1);
        chk("lock_data_ready3", 64'(f_data_miso.rd_addr_ready), 64'h0);
        tick();
        f_instr_mosi.rd_addr_valid = 1'b0;
        f_exp_addr.push_back(32'h0000_2040);
        #2;
        chk("after_lock_addr",  64'(f_cb_mosi.rd_addr), 64'h2040);
        chk("after_lock_ready", 64'(f_data_miso.rd_addr_ready), 64'h1);
        tick();
        f_data_mosi.rd_addr_valid = 1'b0;
        f_slv_miso.rd_addr_ready  = 1'b0;
        #2;
        chk("lock_ot", 64'(f_ot), 64'h2);

        // Round robin: both continuously valid, expected INSTR, DATA, INSTR, DATA.
        r_slv_miso.rd_addr_ready   = 1'b1;
        r_instr_mosi.rd_addr       = 32'h0000_0100;
        r_instr_mosi.rd_addr_valid = 1'b1;
        r_data_mosi.rd_addr        = 32'h0000_0200;
        r_data_mosi.rd_addr_valid  = 1'b1;
        r_exp_addr.push_back(32'h0000_0100);
        r_exp_addr.push_back(32'h0000_0200);
        r_exp_addr.push_back(32'h0000_0100);
        r_exp_addr.push_back(32'h0000_0200);
        for (int i = 0; i < 4; i++) tick();
        #2;
        chk("rr_ot",          64'(r_ot), 64'h4);
        chk("rr_full_valid",  64'(r_cb_mosi.rd_addr_valid), 64'h0);
        chk("rr_full_iready", 64'(r_instr_miso.rd_addr_ready), 64'h0);
        chk("rr_full_dready", 64'(r_data_miso.rd_addr_ready), 64'h0);
        r_instr_mosi.rd_addr_valid = 1'b0;
        r_data_mosi.rd_addr_valid  = 1'b0;
        tick();

        // Reset with reads outstanding, then a stale response arrives.
        rst = 1'b1;
        tick();
        #2;
        chk("rst_mid_f_ot", 64'(f_ot), 64'h0);
        chk("rst_mid_r_ot", 64'(r_ot), 64'h0);
        rst = 1'b0;
        f_slv_miso.rd_valid = 1'b1;
        f_slv_miso.rd_data  = 32'h0000_DEAD;
        #2;
        chk("unexp_pulse",    64'(f_unexp), 64'h1);
        chk("unexp_instr_vld", 64'(f_instr_miso.rd_valid), 64'h0);
        chk("unexp_data_vld", 64'(f_data_miso.rd_valid), 64'h0);
        chk("unexp_drain",    64'(f_cb_mosi.rd_ready), 64'h1);
        tick();
        f_slv_miso.rd_valid = 1'b0;
        #2;
        chk("unexp_clear",    64'(f_unexp), 64'h0);
        chk("unexp_ot",       64'(f_ot), 64'h0);
        tick();

        chk("f_addr_left", 64'(f_exp_addr.size()), 64'h0);
        chk("r_addr_left", 64'(r_exp_addr.size()), 64'h0);
        chk("f_resp_left", 64'(f_exp_resp.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
